npu_dispatch: RTL and testbench
===============================

NPU_DISPATCH -- requirements
Module: npu_dispatch

Interface
REQ-001 SHALL have parameter DWidth, default 32, meaning host bus data/address width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning buffer base-address width per descriptor field.
REQ-003 SHALL have parameter NUM_CORES, default 2, range 1-16, meaning number of systolic cores dispatched to.
REQ-004 SHALL have parameter CMD_DEPTH, default 8, power of two ≥2, meaning command FIFO depth.
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_i, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have ports cen_i, input, 1, access strobe (1 = access), and wen_i, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports addr_i, input, DWidth, byte address (word index addr_i[5:2]), and wdata_i, input, DWidth, write data.
REQ-009 SHALL have port rdata_o, output, DWidth, registered read data.
REQ-010 SHALL have ports core_start_o, output, NUM_CORES, per-core one-cycle start pulse, and core_done_i, input, NUM_CORES, per-core one-cycle done pulse.
REQ-011 SHALL have ports core_a_base_o, core_w_base_o and core_o_base_o, output, NUM_CORES*ADDR_WIDTH each, and core_dim_o, output, NUM_CORES*17: per-core descriptor, core k in slice k.
REQ-012 SHALL have port irq_o, output, 1, completion interrupt.

Function
REQ-013 Register map: 0x00 A_BASE, 0x04 W_BASE, 0x08 O_BASE, 0x0C DIM (rows[7:0], cols[15:8], mode[16]), all R/W staging; 0x10 PUSH (W, data ignored); 0x14 STATUS (RO); 0x18 DONE_CNT (RO); 0x1C CTRL (bit0 run, R/W); 0x20 CLR (W1C: bit0 irq, bit1 overflow); unmapped reads return 0.
REQ-014 STATUS: [7:0] FIFO count, [8] full, [9] empty, [10] overflow sticky, [11] irq pending, [16+k] core k busy, others 0.
REQ-015 Read at cycle t (cen_i=1, wen_i=0) SHALL present data on rdata_o in cycle t+1; rdata_o holds value otherwise.
REQ-016 PUSH write SHALL enqueue the current staging registers {A,W,O,DIM} as one entry; count increments at that edge.
REQ-017 Full evaluated before same-cycle pop: PUSH while full SHALL be dropped and set overflow; FIFO contents unchanged.
REQ-018 Per-core state: IDLE -> BUSY on its start pulse; BUSY -> IDLE on core_done_i[k]; done_i on IDLE core ignored.
REQ-019 Dispatch cycle: when run=1, FIFO non-empty and ≥1 core IDLE, pop head to lowest-index IDLE core; at most one dispatch per cycle.
REQ-020 core_start_o[k] SHALL be registered, high exactly one cycle after the dispatch cycle; descriptor slice k updated at the same edge and held until next start to core k.
REQ-021 With run=1 and an idle core, start SHALL assert 2 cycles after the PUSH write edge (push edge t, dispatch decision t+1, start high cycle t+2).
REQ-022 done_i[k] and a dispatch to core k in the same cycle cannot coincide (core BUSY); done to core k in cycle t allows dispatch to k in cycle t+1.
REQ-023 DONE_CNT SHALL increment by the number of valid done pulses per cycle, wrapping modulo 2^32.
REQ-024 Clearing run SHALL stop new dispatches only; BUSY cores complete normally.
REQ-025 FIFO pointers wrap modulo CMD_DEPTH; simultaneous push (not full) and pop keeps count unchanged.

Reset
REQ-026 On rst_i: FIFO empty, all cores IDLE, staging/CTRL/DONE_CNT/overflow/irq cleared, rdata_o=0, core_start_o=0, descriptor outputs=0, irq_o=0.
REQ-027 Reset mid-operation SHALL discard queued and in-flight commands; core_done_i arriving after reset release for a pre-reset job is ignored.

Configuration
REQ-028 Macro NPU_DISPATCH_IRQ_EN defined: irq pending set on any valid done pulse, irq_o = pending, cleared by CLR bit0 (set wins over same-cycle clear).
REQ-029 Macro NPU_DISPATCH_IRQ_EN undefined: irq_o tied 0, STATUS[11] reads 0, CLR bit0 ignored; all else identical.

Verification
REQ-030 Reset, run=1, write A=0x100,W=0x200,O=0x300,DIM=0x00010808, PUSH -> core_start_o=2'b01 two cycles later, core 0 slice = 0x100/0x200/0x300/0x10808.
REQ-031 Push 3 commands, run=1, NUM_CORES=2 -> cores 0,1 started in consecutive cycles; third starts one cycle after first core_done_i; DONE_CNT=3 after all done.
REQ-032 run=0, push 9 commands (CMD_DEPTH=8) -> STATUS count=8, full=1, overflow=1; CLR=0x2 -> overflow=0, count stays 8.
REQ-033 core_done_i=2'b11 same cycle with IRQ_EN -> DONE_CNT +2, irq_o=1; CLR=0x1 -> irq_o=0; without IRQ_EN irq_o stays 0.
REQ-034 Assert rst_i while core 1 BUSY and 4 queued -> STATUS reads empty=1, busy=0; later done_i[1] -> DONE_CNT stays 0.

Source files
------------

// File: rtl/npu_dispatch.sv
// npu_dispatch: host-programmed command dispatcher for a bank of systolic cores.
// The host stages a descriptor {A, W, O, DIM} through the register file and pushes
// it into a command FIFO. While run is set, the head command goes to the
// lowest-index idle core, at most one per cycle.
// Optional feature: define NPU_DISPATCH_IRQ_EN to enable the completion interrupt.
// Without it, irq_o stays 0, STATUS[11] reads 0, and CLR bit0 has no effect.
//
// Per-core state (one bit per core)
//   state | meaning
//   IDLE  | core free, eligible for dispatch; done pulses ignored
//   BUSY  | start issued, waiting for core_done_i[k]
module npu_dispatch #(
    parameter int DWidth     = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CORES  = 2,
    parameter int CMD_DEPTH  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cen_i,
    input  logic                            wen_i,
    input  logic [DWidth-1:0]               addr_i,
    input  logic [DWidth-1:0]               wdata_i,
    output logic [DWidth-1:0]               rdata_o,
    output logic [NUM_CORES-1:0]            core_start_o,
    input  logic [NUM_CORES-1:0]            core_done_i,
    output logic [NUM_CORES*ADDR_WIDTH-1:0] core_a_base_o,
    output logic [NUM_CORES*ADDR_WIDTH-1:0] core_w_base_o,
    output logic [NUM_CORES*ADDR_WIDTH-1:0] core_o_base_o,
    output logic [NUM_CORES*17-1:0]         core_dim_o,
    output logic                            irq_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int PtrW = $clog2(CMD_DEPTH);
    localparam int CntW = PtrW + 1;
    localparam int EntW = 3 * ADDR_WIDTH + 17;

    // Staging and control registers
    logic [ADDR_WIDTH-1:0] r_a_base;
    logic [ADDR_WIDTH-1:0] r_w_base;
    logic [ADDR_WIDTH-1:0] r_o_base;
    logic [16:0]           r_dim;
    logic                  r_run;
    logic [31:0]           r_done_cnt;
    logic                  r_overflow;

    // Command FIFO
    logic [EntW-1:0]       r_mem [CMD_DEPTH];
    logic [PtrW-1:0]       r_wptr;
    logic [PtrW-1:0]       r_rptr;
    logic [CntW-1:0]       r_count;

    // Per-core state and descriptor outputs
    logic [NUM_CORES-1:0]            r_core_st;
    logic [NUM_CORES-1:0]            r_start;
    logic [NUM_CORES*ADDR_WIDTH-1:0] r_core_a;
    logic [NUM_CORES*ADDR_WIDTH-1:0] r_core_w;
    logic [NUM_CORES*ADDR_WIDTH-1:0] r_core_o;
    logic [NUM_CORES*17-1:0]         r_core_dim;
    logic [DWidth-1:0]               r_rdata;

    logic [3:0]            w_idx;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_push;
    logic                  w_push_ok;
    logic                  w_clr;
    logic                  w_full;
    logic                  w_empty;
    logic [EntW-1:0]       w_head;
    logic [ADDR_WIDTH-1:0] w_head_a;
    logic [ADDR_WIDTH-1:0] w_head_w;
    logic [ADDR_WIDTH-1:0] w_head_o;
    logic [16:0]           w_head_dim;
    logic [NUM_CORES-1:0]  w_grant;
    logic                  w_disp;
    logic [NUM_CORES-1:0]  w_done_vld;
    logic [4:0]            w_done_num;
    logic                  w_irq_pend;
    logic [31:0]           w_status;
    logic [DWidth-1:0]     w_rdata;
    logic                  w_unused;

    assign w_idx     = addr_i[5:2];
    assign w_wr      = cen_i & wen_i;
    assign w_rd      = cen_i & ~wen_i;
    assign w_push    = w_wr && (w_idx == 4'd4);
    assign w_clr     = w_wr && (w_idx == 4'd8);
    assign w_full    = (r_count == CntW'(CMD_DEPTH));
    assign w_empty   = (r_count == '0);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is dropped.
    assign w_push_ok = w_push && !w_full;
    assign w_unused  = ^{addr_i[DWidth-1:6], addr_i[1:0]};

    assign w_head     = r_mem[r_rptr];
    assign w_head_a   = w_head[EntW-1 -: ADDR_WIDTH];
    assign w_head_w   = w_head[EntW-ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign w_head_o   = w_head[EntW-2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign w_head_dim = w_head[16:0];

    // Pick the lowest-index idle core, and qualify done pulses against BUSY cores.
    always_comb begin
        w_grant    = '0;
        w_done_vld = '0;
        w_done_num = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (r_core_st[k] == ST_IDLE) begin
                w_grant = '0;
                w_grant[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            w_done_vld[k] = core_done_i[k] && (r_core_st[k] == ST_BUSY);
            w_done_num    = w_done_num + 5'(w_done_vld[k]);
        end
    end

    assign w_disp = r_run && !w_empty && (|w_grant);

    // Staging registers, run bit, completion counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a_base   <= '0;
            r_w_base   <= '0;
            r_o_base   <= '0;
            r_dim      <= '0;
            r_run      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    4'd0:    r_a_base <= ADDR_WIDTH'(wdata_i);
                    4'd1:    r_w_base <= ADDR_WIDTH'(wdata_i);
                    4'd2:    r_o_base <= ADDR_WIDTH'(wdata_i);
                    4'd3:    r_dim    <= wdata_i[16:0];
                    4'd7:    r_run    <= wdata_i[0];
                    default: ;
                endcase
            end
            r_done_cnt <= r_done_cnt + 32'(w_done_num);
        end
    end

    // FIFO storage; no reset needed since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= {r_a_base, r_w_base, r_o_base, r_dim};
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_disp) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            case ({w_push_ok, w_disp})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: ;
            endcase
            if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr && wdata_i[1]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Core state, registered start pulse and descriptor latch on dispatch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_core_st  <= '0;
            r_start    <= '0;
            r_core_a   <= '0;
            r_core_w   <= '0;
            r_core_o   <= '0;
            r_core_dim <= '0;
        end else begin
            r_start <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (w_done_vld[k]) begin
                    r_core_st[k] <= ST_IDLE;
                end
                if (w_disp && w_grant[k]) begin
                    r_core_st[k]                           <= ST_BUSY;
                    r_start[k]                             <= 1'b1;
                    r_core_a[k*ADDR_WIDTH +: ADDR_WIDTH]   <= w_head_a;
                    r_core_w[k*ADDR_WIDTH +: ADDR_WIDTH]   <= w_head_w;
                    r_core_o[k*ADDR_WIDTH +: ADDR_WIDTH]   <= w_head_o;
                    r_core_dim[k*17 +: 17]                 <= w_head_dim;
                end
            end
        end
    end

`ifdef NPU_DISPATCH_IRQ_EN
    logic r_irq_pend;

    // Interrupt pending: any valid done sets it, CLR bit0 clears it, set wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_pend <= 1'b0;
        end else if (|w_done_vld) begin
            r_irq_pend <= 1'b1;
        end else if (w_clr && wdata_i[0]) begin
            r_irq_pend <= 1'b0;
        end
    end

    assign w_irq_pend = r_irq_pend;
`else
    assign w_irq_pend = 1'b0;
`endif

    // STATUS word assembly.
    always_comb begin
        w_status                   = '0;
        w_status[7:0]              = 8'(r_count);
        w_status[8]                = w_full;
        w_status[9]                = w_empty;
        w_status[10]               = r_overflow;
        w_status[11]               = w_irq_pend;
        w_status[16 +: NUM_CORES]  = r_core_st;
    end

    // Read mux; unmapped and write-only words return 0.
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            4'd0:    w_rdata = DWidth'(r_a_base);
            4'd1:    w_rdata = DWidth'(r_w_base);
            4'd2:    w_rdata = DWidth'(r_o_base);
            4'd3:    w_rdata = DWidth'(r_dim);
            4'd5:    w_rdata = DWidth'(w_status);
            4'd6:    w_rdata = DWidth'(r_done_cnt);
            4'd7:    w_rdata = DWidth'(r_run);
            default: w_rdata = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
        end
    end

    assign rdata_o       = r_rdata;
    assign core_start_o  = r_start;
    assign core_a_base_o = r_core_a;
    assign core_w_base_o = r_core_w;
    assign core_o_base_o = r_core_o;
    assign core_dim_o    = r_core_dim;
    assign irq_o         = w_irq_pend;

endmodule

// File: tb/tb_npu_dispatch.sv
// Directed bench for npu_dispatch (NUM_CORES=2, CMD_DEPTH=8).
module tb_npu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  start;
    logic [1:0]  done;
    logic [63:0] a_base;
    logic [63:0] w_base;
    logic [63:0] o_base;
    logic [33:0] dim;
    logic        irq;
    logic [31:0] rv;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef NPU_DISPATCH_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    npu_dispatch #(
        .DWidth(32), .ADDR_WIDTH(32), .NUM_CORES(2), .CMD_DEPTH(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .wen_i(wen),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .core_start_o(start), .core_done_i(done),
        .core_a_base_o(a_base), .core_w_base_o(w_base), .core_o_base_o(o_base),
        .core_dim_o(dim), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the write edge.
    task automatic wr(input logic [31:0] ad, input logic [31:0] d);
        cen = 1'b1; wen = 1'b1; addr = ad; wdata = d;
        @(negedge clk);
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] ad, output logic [31:0] d);
        cen = 1'b1; wen = 1'b0; addr = ad;
        @(negedge clk);
        cen = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cen = 1'b0; wen = 1'b0; done = 2'b00; addr = '0; wdata = '0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; wen = 1'b0; done = 2'b00; addr = '0; wdata = '0;

        // Reset state and single command dispatch
        do_reset();
        check("rst_rdata", rdata, 0);
        check("rst_start", start, 0);
        check("rst_irq", irq, 0);
        check("rst_a_base", a_base, 0);
        check("rst_dim", dim, 0);
        rd(32'h14, rv); check("rst_status", rv, 32'h200);

        wr(32'h1C, 32'h1);
        wr(32'h00, 32'h100);
        wr(32'h04, 32'h200);
        wr(32'h08, 32'h300);
        wr(32'h0C, 32'h0001_0808);
        wr(32'h10, 32'h0);
        check("start_early", start, 2'b00);
        idle(1);
        check("start_one", start, 2'b01);
        check("c0_a", a_base[31:0], 32'h100);
        check("c0_w", w_base[31:0], 32'h200);
        check("c0_o", o_base[31:0], 32'h300);
        check("c0_dim", dim[16:0], 17'h10808);
        idle(1);
        check("start_width", start, 2'b00);
        rd(32'h14, rv); check("status_busy0", rv, 32'h0001_0200);
        rd(32'h00, rv); check("rd_a_base", rv, 32'h100);
        rd(32'h0C, rv); check("rd_dim", rv, 32'h0001_0808);
        rd(32'h24, rv); check("rd_unmapped", rv, 0);
        done = 2'b01; idle(1); done = 2'b00;
        rd(32'h18, rv); check("done_cnt_1", rv, 1);
        done = 2'b01; idle(1); done = 2'b00;
        rd(32'h18, rv); check("done_idle_core", rv, 1);

        // Three commands, two cores
        do_reset();
        wr(32'h00, 32'h1000); wr(32'h10, 0);
        wr(32'h00, 32'h2000); wr(32'h10, 0);
        wr(32'h00, 32'h3000); wr(32'h10, 0);
        wr(32'h1C, 32'h1);
        check("q3_start_early", start, 2'b00);
        idle(1);
        check("q3_start_c0", start, 2'b01);
        check("q3_c0_a", a_base[31:0], 32'h1000);
        idle(1);
        check("q3_start_c1", start, 2'b10);
        check("q3_c1_a", a_base[63:32], 32'h2000);
        idle(1);
        check("q3_no_third", start, 2'b00);
        done = 2'b01; idle(1); done = 2'b00;
        check("q3_decision_cycle", start, 2'b00);
        idle(1);
        check("q3_start_third", start, 2'b01);
        check("q3_c0_a3", a_base[31:0], 32'h3000);
        check("q3_c1_held", a_base[63:32], 32'h2000);
        idle(1);
        done = 2'b10; idle(1);
        done = 2'b01; idle(1);
        done = 2'b00;
        rd(32'h18, rv); check("q3_done_cnt", rv, 3);
        rd(32'h14, rv); check("q3_status_idle", rv, 32'h200);

        // Overflow, clear, wrap and simultaneous push/pop
        do_reset();
        repeat (9) wr(32'h10, 0);
        rd(32'h14, rv); check("ovf_status", rv, 32'h508);
        wr(32'h20, 32'h2);
        rd(32'h14, rv); check("ovf_cleared", rv, 32'h108);
        wr(32'h1C, 32'h1);
        idle(3);
        rd(32'h14, rv); check("two_dispatched", rv, 32'h0003_0006);
        done = 2'b01; idle(1); done = 2'b00;
        wr(32'h10, 0);
        idle(2);
        rd(32'h14, rv); check("push_pop_same", rv, 32'h0003_0006);
        rd(32'h18, rv); check("pp_done_cnt", rv, 1);

        // Dual done and interrupt
        do_reset();
        wr(32'h1C, 32'h1);
        wr(32'h10, 0);
        wr(32'h10, 0);
        idle(2);
        rd(32'h14, rv); check("irq_both_busy", rv, 32'h0003_0200);
        done = 2'b11; idle(1); done = 2'b00;
        check("irq_set", irq, IRQ_ON);
        rd(32'h18, rv); check("dual_done_cnt", rv, 2);
        rd(32'h14, rv); check("irq_status", rv, 32'h200 | (32'(IRQ_ON) << 11));
        wr(32'h20, 32'h1);
        check("irq_cleared", irq, 0);
        rd(32'h14, rv); check("irq_status_clr", rv, 32'h200);
        done = 2'b11; idle(1); done = 2'b00;
        rd(32'h18, rv); check("dual_idle_ignored", rv, 2);
        check("irq_idle_done", irq, 0);

        // Reset mid-operation
        do_reset();
        wr(32'h1C, 32'h1);
        wr(32'h00, 32'h55);
        repeat (6) wr(32'h10, 0);
        idle(2);
        rd(32'h14, rv); check("pre_rst_status", rv, 32'h0003_0004);
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        check("mid_rst_start", start, 0);
        check("mid_rst_a", a_base, 0);
        rd(32'h14, rv); check("mid_rst_status", rv, 32'h200);
        rd(32'h1C, rv); check("mid_rst_ctrl", rv, 0);
        rd(32'h00, rv); check("mid_rst_stage", rv, 0);
        done = 2'b10; idle(1); done = 2'b00;
        rd(32'h18, rv); check("stale_done", rv, 0);
        idle(2);
        check("no_start_after_rst", start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
